// File: rtl/host_wire_sequencer.sv
// Host wire-in/wire-out to emulator ready/valid bridge: LOAD -> RUN -> DONE session sequencer.
// Optional sticky drop flags on `overrun` when HOST_WIRE_OVERRUN_EN is defined.
module host_wire_sequencer #(
  parameter int DATA_W = 32,
  parameter int INSN_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_rst_wire,
  input  logic [31:0]       cfg_host_steps,
  input  logic [CNT_W-1:0]  cfg_insn_count,
  input  logic [31:0]       insn_bits0_wire,
  input  logic [31:0]       insn_bits1_wire,
  input  logic              insn_valid_wire,
  output logic              insns_ready_wire,
  input  logic [DATA_W-1:0] in_bits_wire,
  input  logic              in_valid_wire,
  output logic              in_ready_wire,
  output logic              out_valid_wire,
  output logic [DATA_W-1:0] out_bits_wire,
  input  logic              out_ready_wire,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn_bits,
  input  logic              insn_ready,
  output logic              io_i_valid,
  output logic [DATA_W-1:0] io_i_bits,
  input  logic              io_i_ready,
  input  logic              io_o_valid,
  input  logic [DATA_W-1:0] io_o_bits,
  output logic              io_o_ready,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  insn_count,
  output logic [31:0]       step_count,
  output logic              done,
  output logic [2:0]        overrun
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  state_t              r_state, w_next;
  logic                r_insn_q, r_in_q, r_out_q;
  logic                r_insn_full, r_in_full, r_out_full;
  logic [INSN_W-1:0]   r_insn_data;
  logic [DATA_W-1:0]   r_in_data, r_out_data;
  logic [CNT_W-1:0]    r_insn_count, r_cfg_count;
  logic [31:0]         r_step_count, r_cfg_steps;

  logic w_clr, w_load, w_run;
  logic w_insn_rise, w_in_rise, w_out_rise;
  logic w_insn_cap, w_in_cap, w_out_cap, w_out_deq;
  logic w_insn_hs, w_in_hs;

  // Soft reset acts as a full clear for everything except the edge detectors.
  assign w_clr  = reset | host_rst_wire;
  assign w_load = (r_state == S_LOAD) & ~w_clr;
  assign w_run  = (r_state == S_RUN) & ~w_clr;

  assign w_insn_rise = insn_valid_wire & ~r_insn_q;
  assign w_in_rise   = in_valid_wire & ~r_in_q;
  assign w_out_rise  = out_ready_wire & ~r_out_q;

  assign w_insn_cap = w_insn_rise & (r_state == S_LOAD) & ~r_insn_full;
  assign w_in_cap   = w_in_rise & (r_state == S_RUN) & ~r_in_full;
  assign w_out_deq  = w_out_rise & (r_state == S_RUN) & r_out_full;
  assign w_insn_hs  = insn_valid & insn_ready;
  assign w_in_hs    = io_i_valid & io_i_ready;
  assign w_out_cap  = io_o_valid & io_o_ready;

  always_ff @(posedge clock) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cfg_host_steps != 32'd0) w_next = S_LOAD;
      S_LOAD: if ((r_insn_count == r_cfg_count) && !r_insn_full) w_next = S_RUN;
      S_RUN:  if (w_out_deq && ((r_step_count + 32'd1) == r_cfg_steps)) w_next = S_DONE;
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    insns_ready_wire = w_load & ~r_insn_full;
    in_ready_wire    = w_run & ~r_in_full;
    io_o_ready       = w_run & ~r_out_full;
    insn_valid       = r_insn_full & ~w_clr;
    io_i_valid       = r_in_full & ~w_clr;
    out_valid_wire   = r_out_full & ~w_clr;
    done             = (r_state == S_DONE);
    state            = r_state;
  end

  assign insn_bits     = r_insn_data;
  assign io_i_bits     = r_in_data;
  assign out_bits_wire = r_out_data;
  assign insn_count    = r_insn_count;
  assign step_count    = r_step_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_insn_q <= 1'b0;
      r_in_q   <= 1'b0;
      r_out_q  <= 1'b0;
    end else begin
      r_insn_q <= insn_valid_wire;
      r_in_q   <= in_valid_wire;
      r_out_q  <= out_ready_wire;
    end
  end

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_insn_full  <= 1'b0;
      r_in_full    <= 1'b0;
      r_out_full   <= 1'b0;
      r_insn_data  <= '0;
      r_in_data    <= '0;
      r_out_data   <= '0;
      r_insn_count <= '0;
      r_step_count <= '0;
      r_cfg_count  <= '0;
      r_cfg_steps  <= '0;
    end else begin
      if (r_state == S_IDLE && cfg_host_steps != 32'd0) begin
        r_cfg_steps <= cfg_host_steps;
        r_cfg_count <= cfg_insn_count;
      end
      if (w_insn_cap) begin
        r_insn_full <= 1'b1;
        r_insn_data <= INSN_W'({insn_bits1_wire, insn_bits0_wire});
      end else if (w_insn_hs) begin
        r_insn_full  <= 1'b0;
        r_insn_count <= r_insn_count + CNT_W'(1);
      end
      if (w_in_cap) begin
        r_in_full <= 1'b1;
        r_in_data <= in_bits_wire;
      end else if (w_in_hs) begin
        r_in_full <= 1'b0;
      end
      if (w_out_cap) begin
        r_out_full <= 1'b1;
        r_out_data <= io_o_bits;
      end else if (w_out_deq) begin
        r_out_full   <= 1'b0;
        r_step_count <= r_step_count + 32'd1;
      end
    end
  end

`ifdef HOST_WIRE_OVERRUN_EN
  logic [2:0] r_ovr;
  logic       w_insn_drop, w_in_drop, w_out_drop;
  // For the output path a "drop" is a dequeue strobe with nothing held.
  assign w_insn_drop = w_insn_rise & ~w_insn_cap;
  assign w_in_drop   = w_in_rise & ~w_in_cap;
  assign w_out_drop  = w_out_rise & ~w_out_deq;

  always_ff @(posedge clock) begin
    if (w_clr) r_ovr <= 3'b000;
    else       r_ovr <= r_ovr | {w_out_drop, w_in_drop, w_insn_drop};
  end
  assign overrun = r_ovr;
`else
  assign overrun = 3'b000;
`endif

endmodule

// File: tb/tb_host_wire_sequencer.sv
// Directed bench for host_wire_sequencer: zero-count session, soft reset mid-load,
// 36-instruction load with hold/drop, and a 4-step run to DONE.
module tb_host_wire_sequencer;
  logic        clock = 1'b0;
  logic        reset, host_rst_wire;
  logic [31:0] cfg_host_steps;
  logic [15:0] cfg_insn_count;
  logic [31:0] insn_bits0_wire, insn_bits1_wire;
  logic        insn_valid_wire, insns_ready_wire;
  logic [31:0] in_bits_wire;
  logic        in_valid_wire, in_ready_wire;
  logic        out_valid_wire;
  logic [31:0] out_bits_wire;
  logic        out_ready_wire;
  logic        insn_valid, insn_ready;
  logic [63:0] insn_bits;
  logic        io_i_valid, io_i_ready;
  logic [31:0] io_i_bits;
  logic        io_o_valid, io_o_ready;
  logic [31:0] io_o_bits;
  logic [1:0]  state;
  logic [15:0] insn_count;
  logic [31:0] step_count;
  logic        done;
  logic [2:0]  overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int beats   = 0;
  int b0;

  host_wire_sequencer dut (
    .clock(clock), .reset(reset), .host_rst_wire(host_rst_wire),
    .cfg_host_steps(cfg_host_steps), .cfg_insn_count(cfg_insn_count),
    .insn_bits0_wire(insn_bits0_wire), .insn_bits1_wire(insn_bits1_wire),
    .insn_valid_wire(insn_valid_wire), .insns_ready_wire(insns_ready_wire),
    .in_bits_wire(in_bits_wire), .in_valid_wire(in_valid_wire), .in_ready_wire(in_ready_wire),
    .out_valid_wire(out_valid_wire), .out_bits_wire(out_bits_wire), .out_ready_wire(out_ready_wire),
    .insn_valid(insn_valid), .insn_bits(insn_bits), .insn_ready(insn_ready),
    .io_i_valid(io_i_valid), .io_i_bits(io_i_bits), .io_i_ready(io_i_ready),
    .io_o_valid(io_o_valid), .io_o_bits(io_o_bits), .io_o_ready(io_o_ready),
    .state(state), .insn_count(insn_count), .step_count(step_count),
    .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (insn_valid && insn_ready) beats <= beats + 1;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe_insn(input logic [31:0] hi, input logic [31:0] lo);
    insn_bits1_wire = hi;
    insn_bits0_wire = lo;
    insn_valid_wire = 1'b1;
    tick();
    insn_valid_wire = 1'b0;
    tick();
  endtask

  logic [31:0] in_vec  [4] = '{32'h0, 32'h4, 32'h9, 32'hf};
  logic [31:0] out_vec [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
  logic [2:0]  ovr_exp;

  initial begin
`ifdef HOST_WIRE_OVERRUN_EN
    ovr_exp = 3'b001;
`else
    ovr_exp = 3'b000;
`endif
    reset = 1'b1; host_rst_wire = 1'b0;
    cfg_host_steps = '0; cfg_insn_count = '0;
    insn_bits0_wire = '0; insn_bits1_wire = '0; insn_valid_wire = 1'b0;
    in_bits_wire = '0; in_valid_wire = 1'b0; out_ready_wire = 1'b0;
    insn_ready = 1'b0; io_i_ready = 1'b0; io_o_valid = 1'b0; io_o_bits = '0;
    @(negedge clock);
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_insns_ready", insns_ready_wire, 0);
    chk("rst_in_ready", in_ready_wire, 0);
    chk("rst_io_o_ready", io_o_ready, 0);
    chk("rst_insn_valid", insn_valid, 0);
    chk("rst_io_i_valid", io_i_valid, 0);
    chk("rst_out_valid", out_valid_wire, 0);
    chk("rst_counts", {insn_count, step_count}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();
    chk("idle_hold", state, 0);

    // Zero-instruction session: IDLE -> LOAD -> RUN in two cycles.
    cfg_insn_count = 16'd0; cfg_host_steps = 32'd1;
    tick();
    chk("zc_load", state, 1);
    tick();
    chk("zc_run", state, 2);
    chk("zc_in_ready", in_ready_wire, 1);
    chk("zc_io_o_ready", io_o_ready, 1);
    chk("zc_insns_ready", insns_ready_wire, 0);
    strobe_insn(32'h1, 32'h2);
    chk("zc_insn_ignored", insn_valid, 0);
    host_rst_wire = 1'b1; cfg_host_steps = 32'd0;
    #1;
    chk("hr_in_ready_gated", in_ready_wire, 0);
    tick();
    chk("hr_idle", state, 0);
    chk("hr_overrun_clr", overrun, 0);

    // Soft reset in the middle of a load.
    cfg_insn_count = 16'd20; cfg_host_steps = 32'd4; host_rst_wire = 1'b0;
    tick();
    chk("b_load", state, 1);
    insn_ready = 1'b1;
    for (int i = 0; i < 10; i++) strobe_insn(32'h0, i);
    chk("b_count10", insn_count, 10);
    insn_ready = 1'b0;
    insn_bits0_wire = 32'hAA; insn_valid_wire = 1'b1;
    tick();
    chk("b_pending", insn_valid, 1);
    insn_valid_wire = 1'b0; host_rst_wire = 1'b1; cfg_host_steps = 32'd0;
    #1;
    chk("b_valid_gated", insn_valid, 0);
    tick();
    host_rst_wire = 1'b0;
    chk("b_idle", state, 0);
    chk("b_count_clr", insn_count, 0);
    chk("b_valid_clr", insn_valid, 0);

    // Main session: 36 instructions, 4 steps.
    b0 = beats;
    cfg_insn_count = 16'd36; cfg_host_steps = 32'd4;
    tick();
    chk("m_load", state, 1);
    insn_bits1_wire = 32'h80; insn_bits0_wire = 32'h1; insn_valid_wire = 1'b1;
    repeat (5) tick();
    chk("m_hold_valid", insn_valid, 1);
    chk("m_hold_bits", insn_bits, 64'h00000080_00000001);
    chk("m_hold_ready", insns_ready_wire, 0);
    chk("m_hold_no_ovr", overrun, 0);
    insn_valid_wire = 1'b0; insn_bits0_wire = 32'h2;
    tick();
    insn_valid_wire = 1'b1;
    tick();
    insn_valid_wire = 1'b0;
    tick();
    chk("m_no_overwrite", insn_bits, 64'h00000080_00000001);
    chk("m_drop_ovr", overrun, ovr_exp);
    chk("m_no_beat_yet", beats - b0, 0);
    insn_ready = 1'b1;
    tick();
    chk("m_first_beat", beats - b0, 1);
    chk("m_count1", insn_count, 1);
    chk("m_drained", insn_valid, 0);
    for (int i = 1; i < 36; i++) strobe_insn(32'h0, 32'h100 + i);
    chk("m_count36", insn_count, 36);
    chk("m_beats36", beats - b0, 36);
    chk("m_still_load", state, 1);
    tick();
    chk("m_run", state, 2);
    insn_ready = 1'b0;

    for (int k = 0; k < 4; k++) begin
      in_bits_wire = in_vec[k]; in_valid_wire = 1'b1;
      tick();
      in_valid_wire = 1'b0;
      chk("r_io_i_valid", io_i_valid, 1);
      chk("r_io_i_bits", io_i_bits, in_vec[k]);
      chk("r_in_full", in_ready_wire, 0);
      io_i_ready = 1'b1;
      tick();
      io_i_ready = 1'b0;
      chk("r_io_i_drained", io_i_valid, 0);
      chk("r_io_o_ready", io_o_ready, 1);
      io_o_valid = 1'b1; io_o_bits = out_vec[k];
      tick();
      io_o_valid = 1'b0;
      chk("r_out_valid", out_valid_wire, 1);
      chk("r_out_bits", out_bits_wire, out_vec[k]);
      chk("r_out_full", io_o_ready, 0);
      out_ready_wire = 1'b1;
      tick();
      out_ready_wire = 1'b0;
      chk("r_step", step_count, k + 1);
      chk("r_out_cleared", out_valid_wire, 0);
      tick();
    end
    chk("d_state", state, 3);
    chk("d_done", done, 1);
    chk("d_in_ready", in_ready_wire, 0);
    chk("d_io_o_ready", io_o_ready, 0);
    chk("d_insns_ready", insns_ready_wire, 0);
    chk("d_steps", step_count, 4);
    chk("d_ovr_sticky", overrun, ovr_exp);
    tick();
    chk("d_held", state, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
